// File: rtl/ee201_numlock_pkg.sv
// Shared definitions for the numlock state machine: state codes, combination and timer loads.
package ee201_numlock_pkg;

  typedef enum logic [3:0] {
    ST_INITIAL = 4'd0,
    ST_G1      = 4'd1,
    ST_G11     = 4'd2,
    ST_G110    = 4'd3,
    ST_G1101   = 4'd4,
    ST_OPENING = 4'd5,
    ST_BAD     = 4'd6
  } state_t;

  localparam int unsigned COMBO_LEN = 5;
  // Combination U,U,Z,U,Z written first-event-in-MSB; 1 means U, 0 means Z.
  localparam logic [COMBO_LEN-1:0] COMBO = 5'b11010;

  localparam logic [3:0] OPEN_TICKS = 4'd15;
  localparam logic [3:0] BAD_TICKS  = 4'd7;
  localparam logic [3:0] FAIL_MAX   = 4'd15;

  // Which button the given sequence state is waiting for (1 = U, 0 = Z).
  function automatic logic combo_expects_u(input state_t s);
    logic want;
    want = 1'b0;
    case (s)
      ST_INITIAL: want = COMBO[4];
      ST_G1:      want = COMBO[3];
      ST_G11:     want = COMBO[2];
      ST_G110:    want = COMBO[1];
      ST_G1101:   want = COMBO[0];
      default:    want = 1'b0;
    endcase
    return want;
  endfunction

  function automatic state_t combo_advance(input state_t s);
    state_t nxt;
    nxt = ST_INITIAL;
    case (s)
      ST_INITIAL: nxt = ST_G1;
      ST_G1:      nxt = ST_G11;
      ST_G11:     nxt = ST_G110;
      ST_G110:    nxt = ST_G1101;
      ST_G1101:   nxt = ST_OPENING;
      default:    nxt = ST_INITIAL;
    endcase
    return nxt;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == FAIL_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/ee201_edge_latch.sv
// Rising-edge detector with a pending latch that holds an edge until the next ce cycle.
module ee201_edge_latch (
  input  logic ClkPort,
  input  logic reset,
  input  logic ce,
  input  logic level,
  output logic ev
);

  logic prev;
  logic pend;
  logic rise;

  assign rise = level & ~prev;
  // An edge seen on the ce cycle itself is consumed directly and never latched.
  assign ev   = ce & (pend | rise);

  always_ff @(posedge ClkPort) begin
    if (reset) begin
      prev <= level;
      pend <= 1'b0;
    end else begin
      prev <= level;
      if (ce)
        pend <= 1'b0;
      else if (rise)
        pend <= 1'b1;
    end
  end

endmodule

// File: rtl/ee201_numlock_sm.sv
// Numlock FSM: U,U,Z,U,Z opens for 16 ce ticks; a wrong entry locks out for 8 ticks.
module ee201_numlock_sm
  import ee201_numlock_pkg::*;
(
  input  logic       ClkPort,
  input  logic       reset,
  input  logic       ce,
  input  logic       U,
  input  logic       Z,
  output logic [3:0] state_code,
  output logic [3:0] fail_count,
  output logic [3:0] timer,
  output logic       unlock
);

  logic       ev_u;
  logic       ev_z;
  state_t     state;
  state_t     state_n;
  logic [3:0] timer_n;
  logic [3:0] fail_n;

  ee201_edge_latch u_edge_u (
    .ClkPort (ClkPort),
    .reset   (reset),
    .ce      (ce),
    .level   (U),
    .ev      (ev_u)
  );

  ee201_edge_latch u_edge_z (
    .ClkPort (ClkPort),
    .reset   (reset),
    .ce      (ce),
    .level   (Z),
    .ev      (ev_z)
  );

  always_ff @(posedge ClkPort) begin
    if (reset) begin
      state      <= ST_INITIAL;
      timer      <= '0;
      fail_count <= '0;
      unlock     <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      fail_count <= fail_n;
      unlock     <= (state_n == ST_OPENING);
    end
  end

  assign state_code = state;

  always_comb begin
    state_n = state;
    timer_n = timer;
    fail_n  = fail_count;
    if (ce) begin
      case (state)
        ST_INITIAL, ST_G1, ST_G11, ST_G110, ST_G1101: begin
          if (ev_u | ev_z) begin
            // A lone event matching the expected button advances; anything else is a bad attempt.
            if (!(ev_u & ev_z) && (ev_u == combo_expects_u(state))) begin
              state_n = combo_advance(state);
              if (state_n == ST_OPENING) begin
                timer_n = OPEN_TICKS;
                fail_n  = '0;
              end
            end else begin
              state_n = ST_BAD;
              timer_n = BAD_TICKS;
              fail_n  = sat_inc(fail_count);
            end
          end
        end
        ST_OPENING, ST_BAD: begin
          if (timer == '0) begin
            state_n = ST_INITIAL;
            timer_n = '0;
          end else begin
            timer_n = timer - 4'd1;
          end
        end
        default: begin
          state_n = ST_INITIAL;
          timer_n = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ee201_numlock_sm.sv
// Bench for ee201_numlock_sm: per-cycle reference scoreboard plus directed scenario checks.
module tb_ee201_numlock_sm;

  logic       ClkPort = 1'b0;
  logic       reset   = 1'b1;
  logic       ce      = 1'b0;
  logic       U       = 1'b0;
  logic       Z       = 1'b0;
  logic [3:0] state_code;
  logic [3:0] fail_count;
  logic [3:0] timer;
  logic       unlock;

  ee201_numlock_sm dut (
    .ClkPort    (ClkPort),
    .reset      (reset),
    .ce         (ce),
    .U          (U),
    .Z          (Z),
    .state_code (state_code),
    .fail_count (fail_count),
    .timer      (timer),
    .unlock     (unlock)
  );

  always #5 ClkPort = ~ClkPort;

  // ce every fourth cycle, driven away from the active edge
  logic [1:0] ce_cnt = 2'd0;
  always @(negedge ClkPort) begin
    ce_cnt = ce_cnt + 2'd1;
    ce     = (ce_cnt == 2'd0);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model and scoreboard
  typedef struct {
    logic [3:0] st;
    logic [3:0] tm;
    logic [3:0] fc;
    logic       ul;
  } exp_t;

  exp_t sb[$];
  int   m_st = 0;
  int   m_tm = 0;
  int   m_fc = 0;
  bit   m_pu = 0, m_pz = 0, m_prev_u = 0, m_prev_z = 0;
  bit   combo[5] = '{1, 1, 0, 1, 0};

  always @(posedge ClkPort) begin
    bit   ru, rz, eu, ez, bad;
    exp_t e;
    if (reset) begin
      m_prev_u = U; m_prev_z = Z;
      m_pu = 0; m_pz = 0;
      m_st = 0; m_tm = 0; m_fc = 0;
    end else begin
      ru = U && !m_prev_u;
      rz = Z && !m_prev_z;
      m_prev_u = U; m_prev_z = Z;
      if (ce) begin
        eu = m_pu || ru;
        ez = m_pz || rz;
        m_pu = 0; m_pz = 0;
        bad = 0;
        if (m_st <= 4) begin
          if (eu && ez) bad = 1;
          else if (eu || ez) begin
            if (eu == combo[m_st]) begin
              m_st++;
              if (m_st == 5) begin m_tm = 15; m_fc = 0; end
            end else bad = 1;
          end
          if (bad) begin
            m_st = 6; m_tm = 7;
            if (m_fc < 15) m_fc++;
          end
        end else if (m_tm == 0) m_st = 0;
        else m_tm--;
      end else begin
        if (ru) m_pu = 1;
        if (rz) m_pz = 1;
      end
    end
    e.st = 4'(m_st); e.tm = 4'(m_tm); e.fc = 4'(m_fc); e.ul = (m_st == 5);
    sb.push_back(e);
  end

  always @(posedge ClkPort) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_state",  state_code, e.st);
      check("sb_timer",  timer,      e.tm);
      check("sb_fails",  fail_count, e.fc);
      check("sb_unlock", unlock,     e.ul);
    end
  end

  // Stimulus helpers
  task automatic tick_ce();
    @(posedge ClkPort iff ce);
    #1;
  endtask

  // Press starts just after a ce edge, releases before the next one, then waits for it.
  task automatic press(input bit pu, input bit pz);
    @(negedge ClkPort);
    U = pu; Z = pz;
    repeat (2) @(negedge ClkPort);
    U = 1'b0; Z = 1'b0;
    tick_ce();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && state_code != 4'd0; i++) begin
      @(posedge ClkPort);
      #1;
    end
    check(tag, state_code, 0);
    tick_ce();
  endtask

  task automatic do_unlock();
    press(1, 0); check("seq_g1",    state_code, 1);
    press(1, 0); check("seq_g11",   state_code, 2);
    press(0, 1); check("seq_g110",  state_code, 3);
    press(1, 0); check("seq_g1101", state_code, 4);
    press(0, 1); check("seq_open",  state_code, 5);
    check("open_unlock", unlock, 1);
    check("open_timer",  timer, 15);
    check("open_fails",  fail_count, 0);
  endtask

  int  exp_fc;
  int  n;
  bit  found;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; U = 1'b0; Z = 1'b0;
    repeat (3) @(posedge ClkPort);
    #1;
    check("rst_state",  state_code, 0);
    check("rst_fails",  fail_count, 0);
    check("rst_timer",  timer, 0);
    check("rst_unlock", unlock, 0);
    @(negedge ClkPort);
    reset = 1'b0;
    tick_ce();

    // Full unlock; OPENING must last 16 ce ticks
    do_unlock();
    n = 0;
    while (unlock && n < 40) begin
      tick_ce();
      n++;
    end
    check("open_ticks",      n, 16);
    check("open_exit_state", state_code, 0);
    check("open_exit_fails", fail_count, 0);
    check("open_exit_timer", timer, 0);

    // Wrong event: U then Z
    press(1, 0); check("bad_g1", state_code, 1);
    press(0, 1);
    check("bad_state", state_code, 6);
    check("bad_timer", timer, 7);
    check("bad_fails", fail_count, 1);
    for (int k = 6; k >= 0; k--) begin
      tick_ce();
      check("bad_count", timer, 32'(k));
      check("bad_hold",  state_code, 6);
    end
    tick_ce();
    check("bad_exit_state", state_code, 0);
    check("bad_exit_timer", timer, 0);

    // U pulse seen only on a non-ce cycle, low again by the next ce
    repeat (3) @(negedge ClkPort);
    U = 1'b1;
    @(negedge ClkPort);
    U = 1'b0;
    tick_ce();
    check("pend_g1", state_code, 1);

    // Simultaneous events in G11
    press(1, 0); check("sim_g11", state_code, 2);
    press(1, 1);
    check("sim_bad",   state_code, 6);
    check("sim_fails", fail_count, 2);
    wait_idle("sim_idle");

    // 17 bad attempts with presses during BAD
    exp_fc = 2;
    for (int a = 0; a < 17; a++) begin
      press(0, 1);
      exp_fc = (exp_fc < 15) ? exp_fc + 1 : 15;
      check("sat_bad",   state_code, 6);
      check("sat_fails", fail_count, 32'(exp_fc));
      press(1, 0);
      check("disc_u_state", state_code, 6);
      press(0, 1);
      check("disc_z_state", state_code, 6);
      check("disc_fails",   fail_count, 32'(exp_fc));
      wait_idle("sat_idle");
    end
    check("sat_final", fail_count, 15);

    // Unlock clears saturated fail_count, then reset mid-OPENING with U held
    do_unlock();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge ClkPort);
      #1;
      if (timer == 4'd9) found = 1;
    end
    check("reach_timer9", found, 1);
    @(negedge ClkPort);
    U = 1'b1;
    reset = 1'b1;
    @(posedge ClkPort);
    #1;
    check("rmid_state",  state_code, 0);
    check("rmid_timer",  timer, 0);
    check("rmid_unlock", unlock, 0);
    check("rmid_fails",  fail_count, 0);
    @(negedge ClkPort);
    reset = 1'b0;
    repeat (3) tick_ce();
    check("held_u_state",  state_code, 0);
    check("held_u_unlock", unlock, 0);
    @(negedge ClkPort);
    U = 1'b0;
    repeat (2) tick_ce();
    check("final_state", state_code, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
